// File: rtl/buffer_wr_arbiter_if.sv
// Frame-buffer write-port bundle: camera stream, CPU handshake, clear control
// and the arbitrated write port toward the buffer.
interface buffer_wr_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          cam_valid;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ack;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;

    modport master (
        output cam_valid, cam_addr, cam_data,
        output cpu_req, cpu_addr, cpu_data,
        output clr_start, clr_color,
        input  cpu_ack, clr_busy, clr_done,
        input  mem_addr, mem_data, mem_we
    );

    modport slave (
        input  cam_valid, cam_addr, cam_data,
        input  cpu_req, cpu_addr, cpu_data,
        input  clr_start, clr_color,
        output cpu_ack, clr_busy, clr_done,
        output mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/buffer_wr_arbiter.sv
// Fixed-priority write-port arbiter for the frame buffer: camera > clear engine > CPU.
// All outputs registered; a grant in cycle t appears on the write port in cycle t+1.
module buffer_wr_arbiter #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    buffer_wr_arbiter_if.slave    bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] CADDR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] caddr_q, caddr_d;
    logic [DW-1:0] color_q, color_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          clr_busy_q, clr_busy_d;
    logic          clr_done_q, clr_done_d;

    logic          gnt_cam_s, gnt_clr_s, gnt_cpu_s;

    // Per-cycle grant; the ack exclusion stops a second write while the CPU drops its request
    always_comb begin
        gnt_cam_s = bus.cam_valid;
        gnt_clr_s = !bus.cam_valid && (state_q == ST_CLEAR);
        gnt_cpu_s = !bus.cam_valid && (state_q == ST_IDLE) && bus.cpu_req && !cpu_ack_q;
    end

    // Next-state, clear counter and write-port values
    always_comb begin
        state_d    = state_q;
        caddr_d    = caddr_q;
        color_d    = color_q;
        clr_done_d = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = gnt_cam_s | gnt_clr_s | gnt_cpu_s;
        cpu_ack_d  = gnt_cpu_s;

        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_d = ST_CLEAR;
                    caddr_d = {AW{1'b0}};
                    color_d = bus.clr_color;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (gnt_clr_s) begin
                    caddr_d = caddr_q + CADDR_ONE;
                    if (caddr_q == CADDR_LAST) begin
                        state_d    = ST_IDLE;
                        clr_done_d = 1'b1;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else begin
                    caddr_d = caddr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                caddr_d = {AW{1'b0}};
            end
        endcase

        if (gnt_cam_s) begin
            mem_addr_d = bus.cam_addr;
            mem_data_d = bus.cam_data;
        end else if (gnt_clr_s) begin
            mem_addr_d = caddr_q;
            mem_data_d = color_q;
        end else if (gnt_cpu_s) begin
            mem_addr_d = bus.cpu_addr;
            mem_data_d = bus.cpu_data;
        end else begin
            mem_addr_d = mem_addr_q;
            mem_data_d = mem_data_q;
        end

        clr_busy_d = (state_d == ST_CLEAR);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            caddr_q    <= {AW{1'b0}};
            color_q    <= {DW{1'b0}};
            mem_we_q   <= 1'b0;
            mem_addr_q <= {AW{1'b0}};
            mem_data_q <= {DW{1'b0}};
            cpu_ack_q  <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            caddr_q    <= caddr_d;
            color_q    <= color_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_ack_q  <= cpu_ack_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;
endmodule

// File: doc/buffer_wr_arbiter.md
# buffer_wr_arbiter

Write-port arbiter and sequencer for the dual-port frame buffer. Three sources share the buffer write port (`addr_in` / `data_in` / `regwrite`):

- the camera capture stream, which cannot be stalled;
- the LM32 CPU, through a request/acknowledge handshake;
- an internal clear engine that fills the whole buffer with one colour.

The block sits between these sources and the buffer's write port. The read port (VGA side) is untouched.

## Interface

Parameters:
- `AW`, 15, buffer address width; must match the frame buffer.
- `DW`, 8, pixel data width; must match the frame buffer.

Ports (name, direction, width, meaning):
- `clk`, in, 1, single clock; the buffer's `clk_w` is driven from this same clock.
- `rst`, in, 1, reset, synchronous and active-low.
- `cam_valid`, in, 1, camera pixel present this cycle.
- `cam_addr`, in, AW, camera pixel address.
- `cam_data`, in, DW, camera pixel value.
- `cpu_req`, in, 1, CPU write request; held until acknowledged.
- `cpu_addr`, in, AW, CPU write address; stable while `cpu_req` is high.
- `cpu_data`, in, DW, CPU write data; stable while `cpu_req` is high.
- `cpu_ack`, out, 1, one-cycle pulse; the CPU write is being performed this cycle.
- `clr_start`, in, 1, pulse; start a full-buffer clear.
- `clr_color`, in, DW, fill value; sampled on the accepted `clr_start`.
- `clr_busy`, out, 1, clear in progress.
- `clr_done`, out, 1, one-cycle pulse on the final clear write.
- `mem_addr`, out, AW, to the buffer's `addr_in`.
- `mem_data`, out, DW, to the buffer's `data_in`.
- `mem_we`, out, 1, to the buffer's `regwrite`.

## Operation

- **State machine:** IDLE, CLEAR.
  - IDLE → CLEAR when `clr_start`=1: latch `clr_color`, set clear address counter `caddr`=0.
  - CLEAR → IDLE on the edge that issues the write for `caddr`=2^AW−1.
  - `clr_start` is ignored while in CLEAR.
- **Per-cycle grant, fixed priority:**
  1. Camera: `cam_valid`=1 always wins; the camera is never stalled and never dropped.
  2. Clear: only in CLEAR state.
  3. CPU: `cpu_req`=1, and `cpu_ack` is not high this cycle.
- A CPU request arriving during CLEAR waits until the clear completes. It is never dropped.
- The `cpu_ack`-high exclusion prevents a double write while the CPU deasserts `cpu_req`. As a result, CPU throughput is at most 1 write per 2 cycles.
- Clear counter `caddr`:
  - increments by 1, modulo 2^AW, only on cycles where clear is granted;
  - holds on cycles lost to the camera;
  - all 2^AW addresses are written exactly once, in ascending order.
- No grant in a cycle → `mem_we`=0 next cycle. `mem_addr`/`mem_data` hold their last values.
- Synchronous reset (`rst`=0) mid-clear aborts the clear: state IDLE, `caddr`=0. A pending CPU request is forgotten and must be presented again.

## Timing

- All outputs are registered. Reset values: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `cpu_ack`=0, `clr_busy`=0, `clr_done`=0.
- Write latency is 1 cycle: a source granted in cycle t produces `mem_we`=1 with its address and data in cycle t+1. The buffer commits the write at the end of t+1.
- `cpu_ack` is high in exactly the cycle its `mem_we` is high.
- `clr_start` sampled in cycle t:
  - `clr_busy`=1 from t+1;
  - first clear grant no earlier than t+1;
  - first clear write no earlier than t+2.
- `clr_done`=1 in the same cycle as the `mem_we` for address 2^AW−1. `clr_busy` drops in that same cycle.
- Uncontended clear:
  - 2^AW consecutive writes;
  - `clr_busy` high for 2^AW cycles;
  - total duration extends by exactly one cycle per camera write that lands inside the clear.
- Simultaneous events:
  - `clr_start` together with `cpu_req` in IDLE, no camera: the CPU is granted in that cycle and the clear begins next cycle.
  - `cam_valid` together with a CPU request: the camera is granted and the CPU waits one or more cycles.

## Test plan

1. **CPU only** (AW=4): `cpu_req` with addr 0x3, data 0xA5, held until ack.
   - Expected: `mem_we`/`mem_addr`=0x3/`mem_data`=0xA5/`cpu_ack`=1 exactly one cycle after the request.
   - Keeping `cpu_req` high for one extra cycle produces no second write.
2. **Camera vs CPU:** `cam_valid` for 3 cycles (addr 0x1–0x3, data 0x10–0x12) while `cpu_req` (addr 0x8, data 0x77) is held.
   - Expected: three camera writes in order, then the CPU write with `cpu_ack`, one cycle after the last camera write.
3. **Clear, uncontended** (AW=4): `clr_start`, `clr_color`=0x00.
   - Expected: 16 writes to addresses 0x0..0xF, `clr_busy` high for 16 cycles, `clr_done` on the addr-0xF write.
   - Read back every location = 0x00.
4. **Clear with camera interference:** start a clear, then inject 2 camera pixels mid-clear.
   - Expected: clear takes 18 cycles and no address is skipped.
   - The final buffer holds the camera values only where the camera write came after the clear write for that address.
5. **CPU during clear:** `cpu_req` raised at clear cycle 5.
   - Expected: `cpu_ack` only after `clr_done`, and the CPU data is present in the buffer afterwards.
6. **Reset mid-clear:** `rst`=0 at clear address 0x7.
   - Expected: next cycle all outputs are 0 and the state is IDLE.
   - A new `clr_start` restarts from address 0x0.
